i2s_pcm_decimator: RTL and testbench
====================================

# i2s_pcm_decimator

Downstream consumer of the I2S receiver's 64-bit stereo frame (`rx_data`, `ws`). It extracts the two 24-bit slot samples, mixes them to mono, and box-car decimates by 2^DECIM_LOG2. It emits 16-bit PCM words through a FIFO with a valid/ready stream for the audio-feature / TinyML front end in the SoC.

## Interface
- DECIM_LOG2, default 2: decimation ratio is 2^DECIM_LOG2 frames per output word (0 allowed = no decimation).
- FIFO_DEPTH_LOG2, default 4: output FIFO depth 2^FIFO_DEPTH_LOG2 words.
- CAPTURE_DLY, default 2: clk cycles from detected `ws` falling edge to `rx_data` capture (≥1).

- clk  in  1  system clock (same clock that drives the receiver)
- rst  in  1  reset, asynchronous, active-high
- en  in  1  block enable
- ws  in  1  word select from receiver
- rx_data  in  64  frame from receiver; [55:32] left, [23:0] right, 24-bit two's complement; [63:56], [31:24] ignored
- m_data  out  16  PCM word at FIFO head
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer accepts `m_data` when `m_valid & m_ready`
- level  out  FIFO_DEPTH_LOG2+1  words in FIFO
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- ovf_clr  in  1  clears `overflow`

## Operation
- Edge detect: `ws` registered each clk; falling edge = registered 1, current 0, while `en`=1.
- Capture: CAPTURE_DLY cycles after the edge, L = rx_data[55:32] and R = rx_data[23:0] are registered (stage C). A new edge inside a pending delay restarts the delay; only one capture happens.
- Mix (C+1): mono = (sext25(L) + sext25(R)) >>> 1, kept as 24 bits (always fits).
- Accumulate (C+2): acc (24+DECIM_LOG2 bits, signed) += mono; phase counter increments.
- On phase wrap (2^DECIM_LOG2-th frame):
  - avg = (acc + mono) >>> DECIM_LOG2, arithmetic shift, floor rounding.
  - Word = avg[23:8] (truncate).
  - Word is pushed to the FIFO.
  - acc and phase are cleared in the same edge.
- FIFO:
  - Registered output, no fall-through. `m_data` is valid only while `m_valid`=1.
  - Push when full with no pop the same cycle: word dropped, FIFO unchanged, `overflow` set.
  - Push and pop the same cycle when full: both happen, no overflow, `level` unchanged.
  - Pop when empty: ignored.
- `overflow`: set has priority over `ovf_clr` in the same cycle.
- `en`=0:
  - No new edges are detected.
  - A pending capture delay is cancelled.
  - In-flight C/C+1 data are discarded; acc and phase are cleared.
  - FIFO contents and read side remain fully functional.
  - Re-enabling starts a fresh decimation group.

## Timing
- Reset values:
  - m_valid=0, m_data=0, level=0, overflow=0.
  - acc=0, phase=0, delay counter idle.
  - Registered `ws` = 0, so a low `ws` out of reset gives no edge.
- Latency: from the cycle the falling edge is detected to `m_valid` rising (FIFO empty, group-completing frame) is CAPTURE_DLY+3 clk.
- Throughput: one capture per `ws` period; pipeline accepts a capture every clk, so any I2S rate ≤ clk is sustained.
- `level` updates on the push/pop clock edge; `m_valid` = (level≠0), registered in the same edge.
- Reset mid-group or mid-pipeline discards all partial state and FIFO contents immediately (async).

## Test plan
- Single-frame mix, DECIM_LOG2=0, four frames: 0x55667788ABCDEFAB → 0x1A33; 0x22334455FBABABAB → 0xEF78; 0xBABABABA55667788 → 0x1099; 0x55667788ABCDEFAB → 0x1A33. Required: words in order, `level` 1→4 with m_ready=0, then drained one per cycle with m_ready=1.
- Decimation (default 4): frames A,A,B,B (A=0x55667788ABCDEFAB, B=0x22334455FBABABAB) → one word 0x04D5. Required: no word after frames 1-3; `m_valid` exactly CAPTURE_DLY+3 clk after the 4th `ws` fall.
- Overflow: DECIM_LOG2=0, m_ready=0, 17 frames. Required: `level`=16, `overflow`=1 after the 17th, and the 17th word absent on drain. Pulse ovf_clr → overflow=0. Then repeat the full push with ovf_clr held high at the dropping cycle → overflow=1.
- Full push/pop collision: FIFO full, m_ready=1 in the same cycle a word is pushed. Required: level stays 16, overflow stays 0, order preserved.
- Enable gating: 2 frames, en=0 for 3 frames, en=1, 4 frames A. Required: exactly one word 0x1A33; no words produced during en=0; FIFO contents from before unchanged.
- Reset mid-operation: assert rst during the C+1 stage of the 3rd frame of a group with 2 words in the FIFO. Required: all outputs at reset values immediately. After release, 4 frames A → single word 0x1A33.

Source files
------------

// File: rtl/i2s_pcm_decimator.sv
// rtl/i2s_pcm_decimator.sv - I2S stereo frame to decimated mono 16-bit PCM stream with output FIFO
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   en               block enable; low cancels capture, flushes the mix pipeline, clears the accumulator
//   ws, rx_data      word select and 64-bit stereo frame from the I2S receiver
//   m_data, m_valid  PCM word at FIFO head, FIFO non-empty
//   m_ready          consumer accept
//   level            words currently held in the FIFO
//   overflow         sticky drop flag, ovf_clr clears it (a drop in the same cycle wins)
module i2s_pcm_decimator #(
    parameter int DECIM_LOG2      = 2,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int CAPTURE_DLY     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       ws,
    input  logic [63:0]                rx_data,
    output logic [15:0]                m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [FIFO_DEPTH_LOG2:0]   level,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int AW    = 24 + DECIM_LOG2;
    localparam int PW    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int CW    = $clog2(CAPTURE_DLY + 1);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;

    localparam logic [PW-1:0]              PHASE_LAST = PW'((1 << DECIM_LOG2) - 1);
    localparam logic [PW-1:0]              PHASE_ONE  = PW'(1);
    localparam logic [CW-1:0]              DLY_LOAD   = CW'(CAPTURE_DLY);
    localparam logic [CW-1:0]              DLY_ONE    = CW'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);
    localparam logic [LW-1:0]              LVL_ONE    = LW'(1);
    localparam logic [LW-1:0]              LVL_FULL   = LW'(DEPTH);

    // Front end: edge detect, capture delay, capture, mix, accumulate
    logic                 ws_q;
    logic [CW-1:0]        dly_q, dly_d;
    logic                 cap_fire;
    logic                 cap_vld_q;
    logic [23:0]          l_q, r_q;
    logic                 mono_vld_q;
    logic [23:0]          mono_q, mono_d;
    logic signed [24:0]   mix_sum;
    logic signed [AW-1:0] acc_q, mono_ext, sum, avg;
    logic [PW-1:0]        phase_q;
    logic                 fall;
    logic                 group_done;
    logic                 push;
    logic [15:0]          word;
    logic                 unused_bits;

    assign fall = en & ws_q & ~ws;

    // A fresh edge reloads the delay (restart), so a capture pending from an
    // earlier edge is abandoned rather than duplicated.
    always_comb begin
        dly_d    = dly_q;
        cap_fire = 1'b0;
        if (!en) begin
            dly_d = '0;
        end else if (fall) begin
            dly_d = DLY_LOAD;
        end else if (dly_q != '0) begin
            dly_d    = dly_q - DLY_ONE;
            cap_fire = (dly_q == DLY_ONE);
        end
    end

    // 25-bit sum cannot overflow; dropping bit 0 is the floor halving.
    assign mix_sum = $signed({l_q[23], l_q}) + $signed({r_q[23], r_q});
    assign mono_d  = mix_sum[24:1];

    assign mono_ext   = AW'($signed(mono_q));
    assign sum        = acc_q + mono_ext;
    assign avg        = sum >>> DECIM_LOG2;
    assign word       = avg[23:8];
    assign group_done = mono_vld_q & (phase_q == PHASE_LAST);
    assign push       = group_done & en;

    assign unused_bits = ^{rx_data[63:56], rx_data[31:24], mix_sum, avg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_q       <= 1'b0;
            dly_q      <= '0;
            cap_vld_q  <= 1'b0;
            l_q        <= '0;
            r_q        <= '0;
            mono_vld_q <= 1'b0;
            mono_q     <= '0;
            acc_q      <= '0;
            phase_q    <= '0;
        end else begin
            ws_q       <= ws;
            dly_q      <= dly_d;
            cap_vld_q  <= cap_fire;
            if (cap_fire) begin
                l_q <= rx_data[55:32];
                r_q <= rx_data[23:0];
            end
            mono_vld_q <= en & cap_vld_q;
            mono_q     <= mono_d;
            if (!en) begin
                acc_q   <= '0;
                phase_q <= '0;
            end else if (mono_vld_q) begin
                if (group_done) begin
                    acc_q   <= '0;
                    phase_q <= '0;
                end else begin
                    acc_q   <= sum;
                    phase_q <= phase_q + PHASE_ONE;
                end
            end
        end
    end

    // Output FIFO
    logic [15:0]                mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]              level_q, level_d;
    logic                       m_valid_q;
    logic                       overflow_q, overflow_d;
    logic                       fifo_full, pop, do_push, drop;

    assign fifo_full = (level_q == LVL_FULL);
    assign pop       = m_ready & m_valid_q;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push   = push & (~fifo_full | pop);
    assign drop      = push & fifo_full & ~pop;

    always_comb begin
        level_d = level_q;
        if (do_push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (!do_push && pop) begin
            level_d = level_q - LVL_ONE;
        end
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            m_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= word;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q    <= level_d;
            m_valid_q  <= (level_d != '0);
            overflow_q <= overflow_d;
        end
    end

    assign m_data   = mem_q[rd_ptr_q];
    assign m_valid  = m_valid_q;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_i2s_pcm_decimator.sv
// tb/tb_i2s_pcm_decimator.sv - self-checking bench for i2s_pcm_decimator
module tb_i2s_pcm_decimator;

    localparam int D = 2;
    localparam logic [63:0] FA = 64'h55667788ABCDEFAB;
    localparam logic [63:0] FB = 64'h22334455FBABABAB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ws = 1'b0;
    logic [63:0] rx_data = '0;
    logic        en0 = 1'b0, en2 = 1'b0;
    logic        m_ready0 = 1'b0, m_ready2 = 1'b0;
    logic        ovf_clr0 = 1'b0, ovf_clr2 = 1'b0;
    logic [15:0] m_data0, m_data2;
    logic        m_valid0, m_valid2, overflow0, overflow2;
    logic [4:0]  level0, level2;

    always #5 clk = ~clk;

    i2s_pcm_decimator #(.DECIM_LOG2(0), .FIFO_DEPTH_LOG2(4), .CAPTURE_DLY(D)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .ws(ws), .rx_data(rx_data),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0),
        .level(level0), .overflow(overflow0), .ovf_clr(ovf_clr0)
    );

    i2s_pcm_decimator #(.DECIM_LOG2(2), .FIFO_DEPTH_LOG2(4), .CAPTURE_DLY(D)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .ws(ws), .rx_data(rx_data),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2),
        .level(level2), .overflow(overflow2), .ovf_clr(ovf_clr2)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] q0[$];
    logic [15:0] q2[$];
    int m_acc = 0;
    int m_ph = 0;

    typedef struct {
        logic [63:0] frame;
        logic [15:0] word;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int mono_of(input logic [63:0] f);
        int l, r;
        l = int'(f[55:32]);
        r = int'(f[23:0]);
        if (l >= 32'h0080_0000) l = l - 32'h0100_0000;
        if (r >= 32'h0080_0000) r = r - 32'h0100_0000;
        return (l + r) >>> 1;
    endfunction

    function automatic logic [15:0] word_of(input int avg);
        logic [31:0] t;
        t = avg;
        return t[23:8];
    endfunction

    task automatic model_frame2(input logic [63:0] f);
        m_acc = m_acc + mono_of(f);
        m_ph  = m_ph + 1;
        if (m_ph == 4) begin
            q2.push_back(word_of(m_acc >>> 2));
            m_acc = 0;
            m_ph  = 0;
        end
    endtask

    task automatic frame_fall(input logic [63:0] f);
        @(negedge clk);
        ws = 1'b1;
        rx_data = f;
        repeat (3) @(negedge clk);
        ws = 1'b0;
    endtask

    task automatic frame(input logic [63:0] f);
        frame_fall(f);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q2.delete();
        m_acc = 0;
        m_ph = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int sel, input string name);
        @(negedge clk);
        if (sel == 0) m_ready0 = 1'b1; else m_ready2 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if ((sel == 0 && q0.size() == 0) || (sel != 0 && q2.size() == 0)) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        if (sel == 0) begin
            chk({name, "_queue_empty"}, q0.size(), 0);
            chk({name, "_level0"}, level0, 0);
            m_ready0 = 1'b0;
        end else begin
            chk({name, "_queue_empty"}, q2.size(), 0);
            chk({name, "_level0"}, level2, 0);
            m_ready2 = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] f;

        fork
            forever begin
                @(negedge clk);
                #1;
                if (!rst) begin
                    if (m_valid0 && m_ready0) begin
                        if (q0.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL dut0_extra_word: got %h expected none", m_data0);
                        end else begin
                            chk("dut0_word", m_data0, q0.pop_front());
                        end
                    end
                    if (m_valid2 && m_ready2) begin
                        if (q2.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL dut2_extra_word: got %h expected none", m_data2);
                        end else begin
                            chk("dut2_word", m_data2, q2.pop_front());
                        end
                    end
                end
            end
        join_none

        tbl[0] = '{64'h55667788ABCDEFAB, 16'h1A33};
        tbl[1] = '{64'h22334455FBABABAB, 16'hEF78};
        tbl[2] = '{64'hBABABABA55667788, 16'h1099};
        tbl[3] = '{64'h55667788ABCDEFAB, 16'h1A33};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_m_valid0", m_valid0, 0);
        chk("rst_m_data0", m_data0, 0);
        chk("rst_level0", level0, 0);
        chk("rst_overflow0", overflow0, 0);
        chk("rst_m_valid2", m_valid2, 0);
        chk("rst_level2", level2, 0);
        rst = 1'b0;

        // Single-frame mix, no decimation
        en0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(tbl[i].word);
            frame(tbl[i].frame);
            chk($sformatf("mix_level_%0d", i), level0, i + 1);
            chk($sformatf("mix_valid_%0d", i), m_valid0, 1);
        end
        @(negedge clk);
        m_ready0 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #2;
            chk($sformatf("mix_drain_level_%0d", k), level0, 4 - k);
        end
        m_ready0 = 1'b0;
        chk("mix_queue_empty", q0.size(), 0);
        chk("mix_valid_after_drain", m_valid0, 0);
        en0 = 1'b0;

        // Decimation by 4 and latency
        do_reset();
        en2 = 1'b1;
        frame(FA);
        chk("dec_nowd_1", m_valid2, 0);
        frame(FA);
        chk("dec_nowd_2", m_valid2, 0);
        frame(FB);
        chk("dec_nowd_3", m_valid2, 0);
        q2.push_back(16'h04D5);
        frame_fall(FB);
        for (int p = 1; p <= D + 3; p++) begin
            @(posedge clk);
            #1;
            if (p == D + 2) chk("dec_latency_early", m_valid2, 0);
            if (p == D + 3) chk("dec_latency_exact", m_valid2, 1);
        end
        chk("dec_level", level2, 1);
        drain(2, "dec");
        en2 = 1'b0;

        // Overflow and ovf_clr
        do_reset();
        en0 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            f = {$urandom, $urandom};
            if (i < 16) q0.push_back(word_of(mono_of(f)));
            frame(f);
            if (i == 15) chk("ovf_not_yet", overflow0, 0);
            chk($sformatf("ovf_level_%0d", i), level0, (i < 16) ? i + 1 : 16);
        end
        chk("ovf_set", overflow0, 1);
        @(negedge clk);
        ovf_clr0 = 1'b1;
        @(negedge clk);
        ovf_clr0 = 1'b0;
        #1;
        chk("ovf_cleared", overflow0, 0);
        ovf_clr0 = 1'b1;
        frame_fall({$urandom, $urandom});
        repeat (D + 3) @(posedge clk);
        @(negedge clk);
        ovf_clr0 = 1'b0;
        #1;
        chk("ovf_set_beats_clr", overflow0, 1);
        chk("ovf_level_still_full", level0, 16);
        drain(0, "ovf");

        // Push and pop collide while full
        do_reset();
        for (int i = 0; i < 16; i++) begin
            f = {$urandom, $urandom};
            q0.push_back(word_of(mono_of(f)));
            frame(f);
        end
        chk("col_full", level0, 16);
        f = {$urandom, $urandom};
        q0.push_back(word_of(mono_of(f)));
        frame_fall(f);
        repeat (D + 2) @(posedge clk);
        @(negedge clk);
        m_ready0 = 1'b1;
        @(negedge clk);
        m_ready0 = 1'b0;
        #1;
        chk("col_level", level0, 16);
        chk("col_no_overflow", overflow0, 0);
        drain(0, "col");
        en0 = 1'b0;

        // Enable gating
        do_reset();
        en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            model_frame2(FB);
            frame(FB);
        end
        chk("en_pre_level", level2, 1);
        model_frame2(FA);
        frame(FA);
        model_frame2(FA);
        frame(FA);
        @(negedge clk);
        en2 = 1'b0;
        m_acc = 0;
        m_ph = 0;
        for (int i = 0; i < 3; i++) begin
            frame(FA);
            chk($sformatf("en_off_level_%0d", i), level2, 1);
        end
        @(negedge clk);
        en2 = 1'b1;
        q2.push_back(16'h1A33);
        for (int i = 0; i < 4; i++) frame(FA);
        chk("en_after_level", level2, 2);
        drain(2, "en");

        // Asynchronous reset in the middle of a group
        do_reset();
        for (int i = 0; i < 8; i++) begin
            model_frame2(FA);
            frame(FA);
        end
        chk("mrst_pre_level", level2, 2);
        frame(FA);
        frame(FA);
        frame_fall(FA);
        repeat (D + 2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_m_valid", m_valid2, 0);
        chk("mrst_level", level2, 0);
        chk("mrst_m_data", m_data2, 0);
        chk("mrst_overflow", overflow2, 0);
        q2.delete();
        m_acc = 0;
        m_ph = 0;
        @(negedge clk);
        rst = 1'b0;
        q2.push_back(16'h1A33);
        for (int i = 0; i < 4; i++) frame(FA);
        chk("mrst_post_level", level2, 1);
        drain(2, "mrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
